// File: rtl/alu_seq_ctrl.sv
// ALU control decoder with an optional multi-cycle MUL/DIV sequencer.
// Define ALU_SEQ_M_EXT_EN to build M-op decode and the MUL/DIV/DONE sequencer.
module alu_seq_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [2:0] ALUop,
  input  logic [2:0] funct3,
  input  logic [1:0] funct7,
  input  logic       flush_i,
  output logic [4:0] control,
  output logic       illegal_o,
  output logic       stall_o,
  output logic       done_o
);

  if (MUL_CYCLES < 1 || DIV_CYCLES < 1) begin : g_param_chk
    $error("alu_seq_ctrl: MUL_CYCLES and DIV_CYCLES must be >= 1");
  end

  logic [4:0] dec_ctrl;
  logic       dec_ill;

  always_comb begin
    dec_ctrl = 5'b00000;
    dec_ill  = 1'b0;
    case (ALUop)
      3'b000: dec_ctrl = 5'b00000;
      3'b001: dec_ctrl = 5'b01010;
      3'b010: begin
        if (funct7[0]) begin
`ifdef ALU_SEQ_M_EXT_EN
          dec_ctrl = {2'b10, funct3};
`else
          dec_ill = 1'b1;
`endif
        end else begin
          case ({funct7[1], funct3})
            4'b0000: dec_ctrl = 5'b00000;
            4'b1000: dec_ctrl = 5'b00001;
            4'b0001: dec_ctrl = 5'b00010;
            4'b0010: dec_ctrl = 5'b00011;
            4'b0011: dec_ctrl = 5'b00100;
            4'b0100: dec_ctrl = 5'b00101;
            4'b0101: dec_ctrl = 5'b00110;
            4'b1101: dec_ctrl = 5'b00111;
            4'b0110: dec_ctrl = 5'b01000;
            4'b0111: dec_ctrl = 5'b01001;
            default: dec_ill  = 1'b1;
          endcase
        end
      end
      3'b011: begin
        case (funct3)
          3'b000: dec_ctrl = 5'b00000;
          3'b010: dec_ctrl = 5'b00011;
          3'b011: dec_ctrl = 5'b00100;
          3'b100: dec_ctrl = 5'b00101;
          3'b110: dec_ctrl = 5'b01000;
          3'b111: dec_ctrl = 5'b01001;
          3'b001: begin
            if (funct7[1]) dec_ill = 1'b1;
            else           dec_ctrl = 5'b00010;
          end
          default: dec_ctrl = funct7[1] ? 5'b00111 : 5'b00110;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) dec_ctrl = 5'b00000;
  end

  // outputs are forced quiet while reset is held, even the combinational decode
  assign illegal_o = rst_n & valid_i & dec_ill;

`ifdef ALU_SEQ_M_EXT_EN
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [4:0]    ctrl_q;
  logic          accept;

  assign accept = rst_n & (state == IDLE) & valid_i & (ALUop == 3'b010) &
                  funct7[0] & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ctrl_q <= 5'b00000;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ctrl_q <= dec_ctrl;
            if (funct3[2]) begin
              cnt   <= CW'(DIV_CYCLES - 1);
              state <= DIV;
            end else begin
              cnt   <= CW'(MUL_CYCLES - 1);
              state <= MUL;
            end
          end
        end
        MUL, DIV: begin
          if (flush_i)         state <= IDLE;
          else if (cnt == '0)  state <= DONE;
          else                 cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    control = 5'b00000;
    stall_o = 1'b0;
    done_o  = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          control = dec_ctrl;
          stall_o = accept;
        end
        MUL, DIV: begin
          control = ctrl_q;
          stall_o = 1'b1;
        end
        default: begin
          control = ctrl_q;
          done_o  = ~flush_i;
        end
      endcase
    end
  end
`else
  assign control = rst_n ? dec_ctrl : 5'b00000;
  assign stall_o = 1'b0;
  assign done_o  = 1'b0;
`endif

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 4: cycles spent in the MUL state per multiply op; legal range is 1 or more.
REQ-002 Parameter DIV_CYCLES, default 32: cycles spent in the DIV state per divide/remainder op; legal range is 1 or more.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 valid_i  input  1  a valid instruction is present in decode.
REQ-006 ALUop  input  3  op class from the main controller.
REQ-007 funct3  input  3  instruction[14:12].
REQ-008 funct7  input  2  {instruction[30], instruction[25]}.
REQ-009 flush_i  input  1  pipeline flush; aborts any sequence in progress.
REQ-010 control  output  5  ALU/MDU operation code.
REQ-011 illegal_o  output  1  no legal decode for the current inputs.
REQ-012 stall_o  output  1  hold the upstream pipeline.
REQ-013 done_o  output  1  one-cycle pulse marking multi-cycle op completion.

Function
REQ-014 Decode in IDLE is combinational from inputs; no X on any output for any input.
REQ-015 ALUop 000: control=00000 (add, address offset). ALUop 001: control=01010 (pass-through).
REQ-016 ALUop 010, funct7[0]=0: {funct7[1],funct3} maps add 0000->00000, sub 1000->00001, sll 0001->00010, slt 0010->00011, sltu 0011->00100, xor 0100->00101, srl 0101->00110, sra 1101->00111, or 0110->01000, and 0111->01001; all other codes are illegal.
REQ-017 ALUop 010, funct7[0]=1 (M-op): control={2'b10,funct3}; funct3[2]=0 is a multiply, funct3[2]=1 is a divide/remainder.
REQ-018 ALUop 011: funct3 maps addi->00000, slti->00011, sltiu->00100, xori->00101, ori->01000, andi->01001, regardless of funct7.
REQ-019 ALUop 011 shifts: funct3=001 with funct7[1]=0 gives slli 00010, and with funct7[1]=1 is illegal; funct3=101 gives srli 00110 when funct7[1]=0 and srai 00111 when funct7[1]=1.
REQ-020 Illegal decode: control=00000, illegal_o=1; any other ALUop value is illegal; illegal_o is gated by valid_i.
REQ-021 FSM states: IDLE, MUL, DIV, DONE.
REQ-022 IDLE: when valid_i=1, the decode is an M-op and flush_i=0, the block latches control into ctrl_q, loads the counter with (MUL_CYCLES-1) or (DIV_CYCLES-1), moves to MUL or DIV, and drives stall_o=1 combinationally in that same cycle.
REQ-023 MUL/DIV: stall_o=1 and control=ctrl_q, held stable regardless of inputs; when cnt=0 the FSM moves to DONE, otherwise cnt decrements.
REQ-024 Timing: the accept cycle plus N cycles in MUL/DIV gives stall_o high for exactly N+1 cycles, N being MUL_CYCLES or DIV_CYCLES.
REQ-025 DONE: stall_o=0, control=ctrl_q, done_o=1 for one cycle, then the FSM returns unconditionally to IDLE; an instruction present during DONE is never accepted.
REQ-026 flush_i=1 in MUL/DIV forces the next state to IDLE with no done_o; flush_i=1 in DONE suppresses done_o; flush_i=1 in IDLE blocks acceptance.
REQ-027 Counter width is clog2(max(MUL_CYCLES,DIV_CYCLES))+1; the counter never wraps below 0.
REQ-028 Outside MUL/DIV/DONE, and outside the accept cycle, stall_o=0 and done_o=0.

Reset
REQ-029 While rst_n=0: state=IDLE, cnt=0, ctrl_q=00000, stall_o=0, done_o=0, illegal_o=0, control=00000.
REQ-030 Reset asserted mid-sequence aborts the sequence immediately (asynchronously), and no done_o is produced after release.

Configuration
REQ-031 Macro ALU_SEQ_M_EXT_EN, when defined: M-op decode and the MUL/DIV sequencer are built as specified in REQ-017 and REQ-021 to REQ-028.
REQ-032 Macro ALU_SEQ_M_EXT_EN, when undefined: ALUop 010 with funct7[0]=1 is illegal; no FSM or counter is built; stall_o=0 and done_o=0 are constant.

Verification
REQ-033 Scenario: ALUop=010, funct7=2'b10, funct3=000, valid_i=1 -> control=00001, stall_o=0, illegal_o=0.
REQ-034 Scenario: ALUop=010, funct7=2'b01, funct3=000, MUL_CYCLES=4 -> stall_o high for 5 cycles, then done_o=1 for 1 cycle, control=10000 throughout.
REQ-035 Scenario: divu (funct3=101, M-op), DIV_CYCLES=32, flush_i pulsed on the 10th stall cycle -> IDLE next cycle, done_o never asserted, stall_o=0.
REQ-036 Scenario: ALUop=011, funct3=001, funct7[1]=1 -> illegal_o=1, control=00000; the same inputs with valid_i=0 -> illegal_o=0.
REQ-037 Scenario: rst_n dropped during DIV with cnt=5 -> all outputs 0 while low, and no done_o after release; inputs held valid after release -> a fresh accept (stall_o=1) and a full 33-cycle stall.
REQ-038 Scenario: build with the macro undefined, M-op inputs applied -> illegal_o=1, stall_o=0, done_o=0.
